// File: rtl/ram_load_sequencer.sv
// Write port A owner for the system RAM: HPS cartridge download, VRAM clear engine, or CPU.
// Also holds the console CPU in reset until image load, VRAM clear and a hold period complete.
module ram_load_sequencer #(
    parameter logic [15:0] CLEAR_BASE  = 16'hC000,
    parameter int          CLEAR_LEN   = 8192,
    parameter int          HOLD_CYCLES = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [15:0] cpu_a,
    input  logic        cpu_we_n,
    input  logic [7:0]  cpu_d,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic        cpu_reset,
    output logic        busy,
    output logic [16:0] load_len,
    output logic        load_ovf
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_HOLD,
        ST_LOAD,
        ST_RUN
    } state_t;

    localparam int              CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [15:0]     CLEAR_LAST = 16'(CLEAR_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [15:0]      ptr;
    logic [CNT_W-1:0] cnt;

    logic        in_range;
    logic [16:0] wr_end;

    assign in_range = (ioctl_addr[24:16] == 9'd0);
    assign wr_end   = {1'b0, ioctl_addr[15:0]} + 17'd1;

    // A download request pre-empts everything except reset and aborts any partial clear.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_CLEAR;
            ptr   <= 16'd0;
            cnt   <= HOLD_LAST;
        end else if (ioctl_download) begin
            state <= ST_LOAD;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ptr <= ptr + 16'd1;
                    if (ptr == CLEAR_LAST) begin
                        state <= ST_HOLD;
                        cnt   <= HOLD_LAST;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) state <= ST_RUN;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_LOAD: begin
                    state <= ST_CLEAR;
                    ptr   <= 16'd0;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Statistics restart on LOAD entry; a write on the final LOAD cycle still counts.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            load_len <= 17'd0;
            load_ovf <= 1'b0;
        end else if (ioctl_download && state != ST_LOAD) begin
            load_len <= 17'd0;
            load_ovf <= 1'b0;
        end else if (state == ST_LOAD && ioctl_wr) begin
            if (!in_range)               load_ovf <= 1'b1;
            else if (wr_end > load_len)  load_len <= wr_end;
        end
    end

    always_comb begin
        ram_address = cpu_a;
        ram_data    = cpu_d;
        ram_wren    = 1'b0;
        case (state)
            ST_CLEAR: begin
                ram_address = CLEAR_BASE + ptr;
                ram_data    = 8'd0;
                ram_wren    = 1'b1;
            end
            ST_LOAD: begin
                ram_address = ioctl_addr[15:0];
                ram_data    = ioctl_dout;
                ram_wren    = ioctl_wr & in_range;
            end
            ST_RUN:  ram_wren = ~cpu_we_n;
            default: ram_wren = 1'b0;
        endcase
    end

    assign busy      = (state != ST_RUN);
    assign cpu_reset = (state != ST_RUN);

endmodule

// File: tb/tb_ram_load_sequencer.sv
// Scoreboard bench for ram_load_sequencer: expected port-A writes are queued by the
// stimulus process and a negedge monitor pops and compares every observed write.
module tb_ram_load_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [15:0] cpu_a = '0;
    logic        cpu_we_n = 1'b1;
    logic [7:0]  cpu_d = '0;
    logic [15:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic        cpu_reset;
    logic        busy;
    logic [16:0] load_len;
    logic        load_ovf;

    ram_load_sequencer dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .cpu_a         (cpu_a),
        .cpu_we_n      (cpu_we_n),
        .cpu_d         (cpu_d),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .cpu_reset     (cpu_reset),
        .busy          (busy),
        .load_len      (load_len),
        .load_ovf      (load_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic        mon_en    = 1'b0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else             pass_cnt++;
    endtask

    // Every port-A write seen while the monitor is enabled must match the queue head.
    always @(negedge clk_sys) begin
        if (mon_en && ram_wren) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {8'd0, ram_address, ram_data}, 32'hFFFF_FFFF);
            end else begin
                check("write_addr_data", {8'd0, ram_address, ram_data}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({16'(16'hC000 + i), 8'h00});
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        tick(2);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_busy",      32'(busy),      32'd1);
        check("rst_load_len",  32'(load_len),  32'd0);
        check("rst_load_ovf",  32'(load_ovf),  32'd0);
        check("rst_wren",      32'(ram_wren),  32'd1);
        check("rst_addr",      32'(ram_address), 32'hC000);
        check("rst_data",      32'(ram_data),  32'd0);
        ioctl_download = 1'b0;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    // Called in a CLEAR cycle with ptr == start; returns in the first RUN cycle.
    task automatic wait_run(input int start, input bit poke);
        tick(8191 - start);
        check("last_clear_wren", 32'(ram_wren), 32'd1);
        check("last_clear_addr", 32'(ram_address), 32'hDFFF);
        tick(1);
        check("hold_wren", 32'(ram_wren), 32'd0);
        check("hold_cpu_reset", 32'(cpu_reset), 32'd1);
        if (poke) begin
            cpu_a = 16'hC123; cpu_d = 8'h77; cpu_we_n = 1'b0;
            #1 check("hold_cpu_write_dropped", 32'(ram_wren), 32'd0);
            tick(1);
            cpu_we_n = 1'b1;
            tick(253);
        end else begin
            tick(254);
        end
        check("hold_end_cpu_reset", 32'(cpu_reset), 32'd1);
        tick(1);
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
    endtask

    task automatic load_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick(1);
        ioctl_wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on clear with exact cpu_reset release timing.
        push_clear(8192);
        do_reset();
        wait_run(0, 1'b0);

        // CPU write in RUN reaches port A in the same cycle.
        exp_q.push_back({16'hC123, 8'h77});
        cpu_a = 16'hC123; cpu_d = 8'h77; cpu_we_n = 1'b0;
        tick(1);
        cpu_we_n = 1'b1;

        // Four-byte download, then full clear with a CPU write attempt during HOLD.
        exp_q.push_back({16'h0000, 8'hA5});
        exp_q.push_back({16'h0001, 8'h5A});
        exp_q.push_back({16'h0002, 8'h3C});
        exp_q.push_back({16'h0003, 8'hC3});
        ioctl_download = 1'b1;
        tick(1);
        check("load_busy", 32'(busy), 32'd1);
        load_byte(25'h0000000, 8'hA5);
        load_byte(25'h0000001, 8'h5A);
        load_byte(25'h0000002, 8'h3C);
        load_byte(25'h0000003, 8'hC3);
        check("dl4_load_len", 32'(load_len), 32'd4);
        check("dl4_load_ovf", 32'(load_ovf), 32'd0);
        ioctl_download = 1'b0;
        push_clear(8192);
        tick(1);
        check("dl4_clear_start_addr", 32'(ram_address), 32'hC000);
        check("dl4_clear_start_wren", 32'(ram_wren), 32'd1);
        wait_run(0, 1'b1);

        // Top-of-RAM byte is written, out-of-range byte is dropped and flagged.
        exp_q.push_back({16'hFFFF, 8'h11});
        ioctl_download = 1'b1;
        tick(1);
        load_byte(25'h000FFFF, 8'h11);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0010000; ioctl_dout = 8'h22;
        #1 check("ovf_write_dropped", 32'(ram_wren), 32'd0);
        tick(1);
        ioctl_wr = 1'b0;
        check("ovf_load_len", 32'(load_len), 32'h10000);
        check("ovf_load_ovf", 32'(load_ovf), 32'd1);
        ioctl_download = 1'b0;
        push_clear(8192);
        tick(1);
        wait_run(0, 1'b0);

        // One-cycle empty download, then abort of the clear at ptr=100.
        ioctl_download = 1'b1;
        tick(1);
        check("empty_dl_len", 32'(load_len), 32'd0);
        check("empty_dl_ovf", 32'(load_ovf), 32'd0);
        ioctl_download = 1'b0;
        push_clear(101);
        tick(1);
        tick(100);
        check("abort_ptr_addr", 32'(ram_address), 32'hC064);
        ioctl_download = 1'b1;
        tick(1);
        check("abort_load_busy", 32'(busy), 32'd1);
        check("abort_load_wren", 32'(ram_wren), 32'd0);
        ioctl_download = 1'b0;
        push_clear(8192);
        tick(1);
        check("restart_addr", 32'(ram_address), 32'hC000);
        wait_run(0, 1'b0);

        // Reset in the middle of a download; later ioctl_wr outside LOAD is ignored.
        exp_q.push_back({16'h0010, 8'h99});
        ioctl_download = 1'b1;
        tick(1);
        load_byte(25'h0000010, 8'h99);
        check("mid_dl_load_len", 32'(load_len), 32'h11);
        push_clear(8192);
        do_reset();
        ioctl_wr = 1'b1; ioctl_addr = 25'h0000005; ioctl_dout = 8'hEE;
        tick(1);
        ioctl_wr = 1'b0;
        check("ignored_wr_load_len", 32'(load_len), 32'd0);
        wait_run(1, 1'b0);

        tick(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
